// File: rtl/preimage_search_if.sv
// -----------------------------------------------------------------------------
// preimage_search_if
//   Request / result handshake bundle for the preimage search engine.
//   The requester side (test controller) uses modport master; the engine
//   uses modport slave.
//
//   Request channel : req_valid, req_ready, target, mask, mode
//   Control         : abort (terminate a running search), busy (sweep active)
//   Result channel  : res_valid, res_ready, res_found, res_input,
//                     res_count, res_aborted
// -----------------------------------------------------------------------------
interface preimage_search_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 7
);
  logic              req_valid;
  logic              req_ready;
  logic [OUT_W-1:0]  target;
  logic [OUT_W-1:0]  mask;
  logic              mode;
  logic              abort;
  logic              busy;
  logic              res_valid;
  logic              res_ready;
  logic              res_found;
  logic [IN_W-1:0]   res_input;
  logic [IN_W:0]     res_count;
  logic              res_aborted;

  modport master (
    output req_valid, target, mask, mode, abort, res_ready,
    input  req_ready, busy, res_valid, res_found, res_input, res_count,
           res_aborted
  );

  modport slave (
    input  req_valid, target, mask, mode, abort, res_ready,
    output req_ready, busy, res_valid, res_found, res_input, res_count,
           res_aborted
  );
endinterface

// File: rtl/preimage_search.sv
// -----------------------------------------------------------------------------
// preimage_search
//   Sweeps every candidate input vector 0 .. 2^IN_W-1 into an external
//   function-under-test and compares the returned response against a masked
//   target. Reports either the first (lowest) matching candidate (mode 0) or
//   the total number of matching candidates (mode 1).
//
//   Ports:
//     clk      sole clock, rising edge
//     rst_n    asynchronous active-low reset
//     ctl      request/result handshake bundle (slave side)
//     cand_o   candidate vector driven to the function-under-test
//     resp_i   response of the function-under-test
//
//   Timing: each candidate is held for RESP_LAT cycles; the response is
//   sampled on the last of those edges (wait counter == 0).
// -----------------------------------------------------------------------------
module preimage_search #(
  parameter int IN_W     = 8,
  parameter int OUT_W    = 7,
  parameter int RESP_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  preimage_search_if.slave  ctl,
  output logic [IN_W-1:0]   cand_o,
  input  logic [OUT_W-1:0]  resp_i
);

  // Wait counter needs at least one bit even when RESP_LAT == 1.
  localparam int WAIT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(RESP_LAT - 1);
  localparam logic [IN_W-1:0]   CAND_LAST   = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [IN_W-1:0]    cand_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [OUT_W-1:0]   target_q;
  logic [OUT_W-1:0]   mask_q;
  logic               mode_q;
  logic [IN_W:0]      count_q;
  logic               found_q;
  logic [IN_W-1:0]    input_q;
  logic               aborted_q;
  logic               req_ready_q;
  logic               busy_q;
  logic               res_valid_q;

  // Combinational view of the current sample.
  logic               match_d;
  logic               sample_d;
  logic               last_d;

  assign match_d  = (((resp_i ^ target_q) & mask_q) == '0);
  assign sample_d = (wait_q == '0);
  assign last_d   = (cand_q == CAND_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      wait_q      <= '0;
      target_q    <= '0;
      mask_q      <= '0;
      mode_q      <= 1'b0;
      count_q     <= '0;
      found_q     <= 1'b0;
      input_q     <= '0;
      aborted_q   <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctl.req_valid && req_ready_q) begin
            target_q    <= ctl.target;
            mask_q      <= ctl.mask;
            mode_q      <= ctl.mode;
            cand_q      <= '0;
            count_q     <= '0;
            found_q     <= 1'b0;
            input_q     <= '0;
            aborted_q   <= 1'b0;
            wait_q      <= WAIT_RELOAD;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_SWEEP;
          end
        end

        ST_SWEEP: begin
          if (ctl.abort) begin
            // Abort wins over a coincident sample; that sample is dropped.
            aborted_q   <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (!sample_d) begin
            wait_q <= wait_q - 1'b1;
          end else begin
            if (match_d) begin
              count_q <= count_q + 1'b1;
              found_q <= 1'b1;
              // Only the lowest matching candidate is reported.
              if (!found_q) begin
                input_q <= cand_q;
              end
            end
            if ((match_d && !mode_q) || last_d) begin
              busy_q      <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              cand_q <= cand_q + 1'b1;
              wait_q <= WAIT_RELOAD;
            end
          end
        end

        ST_DONE: begin
          // cand_o and all result registers hold until the handshake.
          if (ctl.res_ready) begin
            res_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cand_o          = cand_q;
  assign ctl.req_ready   = req_ready_q;
  assign ctl.busy        = busy_q;
  assign ctl.res_valid   = res_valid_q;
  assign ctl.res_found   = found_q;
  assign ctl.res_input   = input_q;
  assign ctl.res_count   = count_q;
  assign ctl.res_aborted = aborted_q;

endmodule

// File: tb/tb_preimage_search.sv
// -----------------------------------------------------------------------------
// tb_preimage_search
//   Drives two engine instances: RESP_LAT=1 against a combinational function
//   (x[6:0] or x[6:0]&7'h3F), and RESP_LAT=3 against a 2-stage registered
//   x[6:0]. Expected results come from a reference sweep model and flow
//   through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_preimage_search;

  typedef struct {
    logic       found;
    logic [7:0] inp;
    logic [8:0] count;
    logic       aborted;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   fsel;
  exp_t sb[$];

  logic [7:0] cand1;
  logic [6:0] resp1;
  logic [7:0] cand3;
  logic [6:0] resp3;
  logic [6:0] pipe_s1;
  logic [6:0] pipe_s2;

  preimage_search_if #(.IN_W(8), .OUT_W(7)) if1 ();
  preimage_search_if #(.IN_W(8), .OUT_W(7)) if3 ();

  preimage_search #(.IN_W(8), .OUT_W(7), .RESP_LAT(1)) dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl    (if1),
    .cand_o (cand1),
    .resp_i (resp1)
  );

  preimage_search #(.IN_W(8), .OUT_W(7), .RESP_LAT(3)) dut3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctl    (if3),
    .cand_o (cand3),
    .resp_i (resp3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    resp1 = (fsel == 1) ? (cand1[6:0] & 7'h3F) : cand1[6:0];
  end

  always_ff @(posedge clk) begin
    pipe_s1 <= cand3[6:0];
    pipe_s2 <= pipe_s1;
  end
  assign resp3 = pipe_s2;

  function automatic logic [6:0] fref(int fs, int x);
    logic [7:0] xv;
    xv = 8'(x);
    return (fs == 1) ? (xv[6:0] & 7'h3F) : xv[6:0];
  endfunction

  // Reference sweep: abort_k = candidate whose sample edge sees abort (-1: none).
  function automatic exp_t model(int fs, logic [6:0] tgt, logic [6:0] msk,
                                 logic mode, int lat, int abort_k);
    exp_t e;
    e.found = 1'b0; e.inp = 8'h00; e.count = 9'd0; e.aborted = 1'b0;
    e.lat = 256 * lat;
    for (int k = 0; k < 256; k++) begin
      if (k == abort_k) begin
        e.aborted = 1'b1;
        e.lat = (k + 1) * lat;
        e.found = (e.count != 0);
        return e;
      end
      if (((fref(fs, k) ^ tgt) & msk) == 7'h00) begin
        if (e.count == 0) e.inp = 8'(k);
        e.count = e.count + 9'd1;
        if (!mode) begin
          e.lat = (k + 1) * lat;
          e.found = 1'b1;
          return e;
        end
      end
    end
    e.found = (e.count != 0);
    return e;
  endfunction

  // One search on the RESP_LAT=1 instance, optional abort and result backpressure.
  task automatic run1(input string name, input int fs, input logic [6:0] tgt,
                      input logic [6:0] msk, input logic mode,
                      input int abort_k, input int hold);
    exp_t e;
    int   lat;
    int   abort_cycle;
    logic [8:0] cnt_snap;
    fsel = fs;
    sb.push_back(model(fs, tgt, msk, mode, 1, abort_k));
    abort_cycle = (abort_k >= 0) ? abort_k + 1 : -1;
    @(negedge clk);
    total++;
    if (if1.req_ready !== 1'b1) begin
      bad++; $display("FAIL %s req_ready_idle got=%b want=1", name, if1.req_ready);
    end
    if1.target = tgt; if1.mask = msk; if1.mode = mode; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    // Disturb the request fields; the latched copy must be used.
    if1.target = ~tgt; if1.mask = 7'h00; if1.mode = ~mode;
    total++;
    if (if1.busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_accept got=%b want=1", name, if1.busy);
    end
    lat = 0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      if1.abort = (c == abort_cycle);
      @(posedge clk); #1;
      if (if1.res_valid === 1'b1) begin lat = c; break; end
    end
    if1.abort = 1'b0;
    e = sb.pop_front();
    total++;
    if (lat == 0) begin
      bad++; $display("FAIL %s timeout got=no_result want=lat%0d", name, e.lat);
    end
    $display("txn %s: found=%0b input=%02h count=%0d aborted=%0b lat=%0d",
             name, if1.res_found, if1.res_input, if1.res_count, if1.res_aborted, lat);
    total++;
    if (lat != e.lat) begin
      bad++; $display("FAIL %s latency got=%0d want=%0d", name, lat, e.lat);
    end
    total++;
    if (if1.res_found !== e.found) begin
      bad++; $display("FAIL %s found got=%b want=%b", name, if1.res_found, e.found);
    end
    total++;
    if (if1.res_input !== e.inp) begin
      bad++; $display("FAIL %s input got=%h want=%h", name, if1.res_input, e.inp);
    end
    total++;
    if (if1.res_count !== e.count) begin
      bad++; $display("FAIL %s count got=%0d want=%0d", name, if1.res_count, e.count);
    end
    total++;
    if (if1.res_aborted !== e.aborted) begin
      bad++; $display("FAIL %s aborted got=%b want=%b", name, if1.res_aborted, e.aborted);
    end
    cnt_snap = if1.res_count;
    // Backpressure: result must hold, new requests must be refused.
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if1.req_valid = 1'b1;
      total++;
      if (if1.res_valid !== 1'b1 || if1.req_ready !== 1'b0 || if1.busy !== 1'b0 ||
          if1.res_count !== cnt_snap || if1.res_input !== e.inp) begin
        bad++;
        $display("FAIL %s hold%0d got=valid%b ready%b busy%b count%0d want=valid1 ready0 busy0 count%0d",
                 name, h, if1.res_valid, if1.req_ready, if1.busy, if1.res_count, cnt_snap);
      end
    end
    @(negedge clk);
    if1.req_valid = 1'b0;
    if1.res_ready = 1'b1;
    @(posedge clk); #1;
    if1.res_ready = 1'b0;
    total++;
    if (if1.res_valid !== 1'b0 || if1.req_ready !== 1'b1) begin
      bad++; $display("FAIL %s handshake got=valid%b ready%b want=valid0 ready1",
                      name, if1.res_valid, if1.req_ready);
    end
  endtask

  task automatic test_reset();
    total++;
    if (if1.req_ready !== 1'b1 || if1.busy !== 1'b0 || if1.res_valid !== 1'b0 ||
        cand1 !== 8'h00 || if1.res_count !== 9'd0 || if3.req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_state got=ready%b busy%b valid%b cand%h count%0d want=ready1 busy0 valid0 cand00 count0",
                      if1.req_ready, if1.busy, if1.res_valid, cand1, if1.res_count);
    end
    $display("txn reset: ready=%0b busy=%0b valid=%0b", if1.req_ready, if1.busy, if1.res_valid);
  endtask

  task automatic test_first_match();
    run1("first_match", 0, 7'h05, 7'h7F, 1'b0, -1, 0);
  endtask

  task automatic test_exhaustive();
    run1("exhaustive", 0, 7'h05, 7'h7F, 1'b1, -1, 0);
  endtask

  task automatic test_no_match();
    run1("no_match", 1, 7'h40, 7'h7F, 1'b1, -1, 0);
    run1("mask0_count", 1, 7'h40, 7'h00, 1'b1, -1, 0);
    run1("mask0_first", 0, 7'h33, 7'h00, 1'b0, -1, 0);
  endtask

  task automatic test_backpressure();
    run1("backpressure", 0, 7'h05, 7'h7F, 1'b0, -1, 10);
  endtask

  task automatic test_abort();
    run1("abort", 0, 7'h05, 7'h7F, 1'b1, 16, 0);
  endtask

  task automatic test_back_to_back();
    run1("b2b_a", 0, 7'h7E, 7'h7F, 1'b0, -1, 0);
    run1("b2b_b", 0, 7'h01, 7'h03, 1'b1, -1, 0);
  endtask

  task automatic test_lat3();
    exp_t e;
    int   lat;
    sb.push_back(model(0, 7'h05, 7'h7F, 1'b0, 3, -1));
    @(negedge clk);
    if3.target = 7'h05; if3.mask = 7'h7F; if3.mode = 1'b0; if3.req_valid = 1'b1;
    @(posedge clk); #1;
    if3.req_valid = 1'b0;
    lat = 0;
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (if3.res_valid === 1'b1) begin lat = c; break; end
      total++;
      if (cand3 !== 8'(c / 3)) begin
        bad++; $display("FAIL lat3 cand_c%0d got=%h want=%h", c, cand3, 8'(c / 3));
      end
    end
    e = sb.pop_front();
    $display("txn lat3: found=%0b input=%02h count=%0d lat=%0d",
             if3.res_found, if3.res_input, if3.res_count, lat);
    total++;
    if (lat != e.lat) begin
      bad++; $display("FAIL lat3 latency got=%0d want=%0d", lat, e.lat);
    end
    total++;
    if (if3.res_input !== e.inp || if3.res_found !== e.found || if3.res_count !== e.count) begin
      bad++; $display("FAIL lat3 result got=%h/%b/%0d want=%h/%b/%0d",
                      if3.res_input, if3.res_found, if3.res_count, e.inp, e.found, e.count);
    end
    @(negedge clk);
    if3.res_ready = 1'b1;
    @(posedge clk); #1;
    if3.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_sweep();
    logic hit;
    fsel = 0;
    @(negedge clk);
    if1.target = 7'h05; if1.mask = 7'h7F; if1.mode = 1'b1; if1.req_valid = 1'b1;
    @(posedge clk); #1;
    if1.req_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (cand1 === 8'h40) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    total++;
    if (!hit) begin
      bad++; $display("FAIL rst_mid reach_cand40 got=%h want=40", cand1);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (if1.req_ready !== 1'b1 || if1.busy !== 1'b0 || if1.res_valid !== 1'b0 ||
        cand1 !== 8'h00 || if1.res_count !== 9'd0 || if1.res_found !== 1'b0) begin
      bad++; $display("FAIL rst_mid outputs got=ready%b busy%b valid%b cand%h count%0d want=ready1 busy0 valid0 cand00 count0",
                      if1.req_ready, if1.busy, if1.res_valid, cand1, if1.res_count);
    end
    $display("txn rst_mid: ready=%0b busy=%0b cand=%02h", if1.req_ready, if1.busy, cand1);
    @(negedge clk);
    rst_n = 1'b1;
    run1("after_reset", 0, 7'h05, 7'h7F, 1'b0, -1, 0);
  endtask

  initial begin
    total = 0; bad = 0; fsel = 0;
    rst_n = 1'b0;
    if1.req_valid = 1'b0; if1.target = '0; if1.mask = '0; if1.mode = 1'b0;
    if1.abort = 1'b0; if1.res_ready = 1'b0;
    if3.req_valid = 1'b0; if3.target = '0; if3.mask = '0; if3.mode = 1'b0;
    if3.abort = 1'b0; if3.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_first_match();
    test_exhaustive();
    test_no_match();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_lat3();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/preimage_search.md
Name: preimage_search

Overview:
Sequential stimulus and inverse-search engine for 8-input/7-output combinational benchmark netlists (PLA-derived, e.g. dc2-class). It is the driving end of the benchmark interface. The engine sweeps candidate input vectors into an external function-under-test, compares the returned output vector against a masked target, and reports either the first preimage or the total number of preimages. It is used for equivalence spot-checks and controllability analysis in the power-aware synthesis flow.

Parameters:
IN_W, 8, candidate/input vector width; sweep covers 0 .. 2^IN_W-1
OUT_W, 7, response/target width
RESP_LAT, 1, edges from a cand_o update to the edge that samples resp_i; legal range >=1 (1 = purely combinational DUT)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid_i  input  1  search request valid
req_ready_o  output  1  engine can accept a request
target_i  input  OUT_W  required output value
mask_i  input  OUT_W  care bits; 1 = compare this bit
mode_i  input  1  0 = stop at first match, 1 = exhaustive count
abort_i  input  1  terminate the running search
cand_o  output  IN_W  candidate driven to the DUT inputs
resp_i  input  OUT_W  DUT outputs
busy_o  output  1  search in progress
res_valid_o  output  1  result valid
res_ready_i  input  1  result consumed
res_found_o  output  1  at least one match
res_input_o  output  IN_W  first (lowest) matching candidate; 0 if none
res_count_o  output  IN_W+1  number of matches seen
res_aborted_o  output  1  search ended by abort_i

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. Every register clears, state=IDLE, all outputs 0 except req_ready_o=1. Reset mid-search discards the search with no result.
- States: IDLE, SWEEP, DONE.
- IDLE: req_ready_o=1. Accept edge (req_valid_i & req_ready_o) does the following:
  - latches target, mask and mode;
  - sets cand_o=0, count=0, first-match flag=0, wait counter=RESP_LAT-1;
  - moves to SWEEP.
- SWEEP: busy_o=1, req_ready_o=0, cand_o held stable while the wait counter is nonzero.
- Sample edge (wait counter==0): match = ((resp_i ^ target) & mask)==0.
  - On match: count+1; if this is the first match, record cand_o into res_input_o.
  - mode 0 with a match: go to DONE.
  - Otherwise, if cand_o==2^IN_W-1: go to DONE.
  - Otherwise: cand_o+1 and wait counter=RESP_LAT-1.
- Latency: each candidate occupies exactly RESP_LAT cycles.
  - First match at candidate k: res_valid_o rises at accept edge + (k+1)*RESP_LAT.
  - Exhaustive sweep or no match: res_valid_o rises at accept edge + 2^IN_W*RESP_LAT.
- res_count_o is IN_W+1 bits wide, so 2^IN_W (all match) is representable with no overflow.
- abort_i:
  - In SWEEP: takes priority over the sample on the same edge; that sample is not counted. Go to DONE with res_aborted_o=1 and found/count/input as accumulated.
  - In IDLE or DONE: ignored.
- DONE:
  - res_valid_o=1; all res_* outputs stable; cand_o holds its last value.
  - res_valid_o & res_ready_i moves to IDLE and clears res_valid_o.
  - A new request is accepted no earlier than the cycle after the result handshake (one bubble).
- res_found_o = (count != 0). res_input_o stays 0 when there is no match.
- Request inputs are ignored when req_ready_o=0. target/mask changes during SWEEP have no effect.
- mask_i=0 makes every candidate match: mode 0 returns candidate 0 after RESP_LAT cycles.

Test Plan:
- Bench DUT f(x)=x[6:0], RESP_LAT=1, target=7'h05, mask=7'h7F, mode 0 -> res_valid 6 cycles after accept; found=1, input=8'h05, count=1, aborted=0.
- Same DUT, mode 1 -> valid 256 cycles after accept; found=1, input=8'h05, count=2 (8'h05, 8'h85).
- f(x)=x[6:0]&7'h3F, target=7'h40, mask=7'h7F, mode 1 -> after 256 cycles: found=0, input=0, count=0. With mask=0, mode 1 -> count=9'd256, input=0.
- RESP_LAT=3 build with a 2-stage registered DUT (response valid at the sampling edge), target=7'h05, mode 0 -> cand_o stable 3 cycles per step; valid 18 cycles after accept; input=8'h05.
- Backpressure/abort:
  - hold res_ready_i=0 for 10 cycles -> result stable, req_ready_o=0;
  - abort_i on the sample edge of cand=8'h10, mode 1, f=x[6:0], target=7'h05 -> aborted=1, count=1, input=8'h05.
- Assert rst_n low mid-SWEEP (cand=8'h40) -> all outputs 0 and req_ready_o=1 immediately; a fresh request after release behaves as in the first scenario.
